xgmii_frame_checker: RTL and testbench

- Receive-side counterpart of the 64-bit XGMII-style frame generator; consumes one data/control block per clock and parses Ethernet frames.
- Detects start/preamble/SFD and delimits frames on terminate. Counts frame length, classifies errors, keeps good/bad frame counters and forwards frame bytes with lane-valid flags.
- Sits on the RX side of the loopback/verification datapath, directly after the MII/BASE-R decode stage.

---
 rtl/xgmii_frame_checker_if.sv | 23 ++
 rtl/xgmii_frame_checker.sv | 224 ++++++++++++++++++++++
 tb/tb_xgmii_frame_checker.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/xgmii_frame_checker_if.sv
// Receive-side XGMII block stream: raw blocks in, registered blocks with
// lane-valid and frame boundary flags out.
interface xgmii_frame_checker_if #(
   parameter int DATA_WIDTH = 64,
   parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] i_rx_data;
   logic [CTRL_WIDTH-1:0] i_rx_ctrl;
   logic [DATA_WIDTH-1:0] o_rx_data;
   logic [CTRL_WIDTH-1:0] o_rx_keep;
   logic                  o_rx_sof;
   logic                  o_rx_eof;

   modport master (
      output i_rx_data, i_rx_ctrl,
      input  o_rx_data, o_rx_keep, o_rx_sof, o_rx_eof
   );

   modport slave (
      input  i_rx_data, i_rx_ctrl,
      output o_rx_data, o_rx_keep, o_rx_sof, o_rx_eof
   );
endinterface

// File: rtl/xgmii_frame_checker.sv
// XGMII 64-bit receive frame checker: finds start/preamble/SFD, delimits
// frames on terminate, measures length, classifies errors and keeps
// good/bad frame counters. Lane 0 is bits [63:56] and is first in time.
// Optional FCS check is compiled in when the macro FCS_CHECK_EN is defined.
//
// state  | meaning
// S_IDLE | between frames, waiting for a start block
// S_RECV | inside a frame, counting and forwarding bytes until terminate
module xgmii_frame_checker #(
   parameter int          DATA_WIDTH     = 64,
   parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
   parameter int          MIN_FRAME_LEN  = 64,
   parameter int          MAX_FRAME_LEN  = 1518,
   parameter int          CNT_WIDTH      = 16,
   parameter logic [7:0]  START_CODE     = 8'hFB,
   parameter logic [7:0]  PREAMBLE_CODE  = 8'h55,
   parameter logic [7:0]  SFD_CODE       = 8'hD5,
   parameter logic [7:0]  TERMINATE_CODE = 8'hFD
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   xgmii_frame_checker_if.slave  bus,
   output logic                  o_frame_done,
   output logic [2:0]            o_frame_err,
   output logic [13:0]           o_frame_len,
   output logic [CNT_WIDTH-1:0]  o_good_count,
   output logic [CNT_WIDTH-1:0]  o_bad_count
);

   localparam logic [13:0] L_MIN = 14'(MIN_FRAME_LEN);
   localparam logic [13:0] L_MAX = 14'(MAX_FRAME_LEN);

   typedef enum logic {S_IDLE, S_RECV} state_t;

   state_t                r_state, w_state_nx;
   logic [13:0]           r_len, w_len_nx;
   logic                  r_first, w_first_nx;
   logic [DATA_WIDTH-1:0] r_rx_data;
   logic [CTRL_WIDTH-1:0] r_rx_keep, w_keep;
   logic                  r_rx_sof, w_sof;
   logic                  r_rx_eof, w_eof;
   logic                  r_done, w_done;
   logic [2:0]            r_err, w_err, w_term_err;
   logic [13:0]           r_flen, w_flen;
   logic [CNT_WIDTH-1:0]  r_good_count, r_bad_count;

   logic                  w_start_lane0, w_start_ok;
   logic [3:0]            w_idx;
   logic [7:0]            w_ctrl_char;
   logic [CTRL_WIDTH-1:0] w_lane_keep;
   logic [14:0]           w_len_sum;
   logic [13:0]           w_len_add;
   logic                  w_fcs_bad;

   // Block decode: start check, first control lane, kept lanes, saturating length
   always_comb begin
      w_start_lane0 = bus.i_rx_ctrl[0] && (bus.i_rx_data[DATA_WIDTH-1 -: 8] == START_CODE);
      w_start_ok    = w_start_lane0;
      for (int j = 1; j < CTRL_WIDTH; j++) begin
         if (bus.i_rx_ctrl[j]) w_start_ok = 1'b0;
         if (j == CTRL_WIDTH - 1) begin
            if (bus.i_rx_data[DATA_WIDTH-1-8*j -: 8] != SFD_CODE) w_start_ok = 1'b0;
         end else begin
            if (bus.i_rx_data[DATA_WIDTH-1-8*j -: 8] != PREAMBLE_CODE) w_start_ok = 1'b0;
         end
      end
      w_idx       = 4'(CTRL_WIDTH);
      w_ctrl_char = 8'h00;
      for (int j = CTRL_WIDTH - 1; j >= 0; j--) begin
         if (bus.i_rx_ctrl[j]) begin
            w_idx       = 4'(j);
            w_ctrl_char = bus.i_rx_data[DATA_WIDTH-1-8*j -: 8];
         end
      end
      for (int j = 0; j < CTRL_WIDTH; j++) begin
         w_lane_keep[j] = (4'(j) < w_idx);
      end
      w_len_sum = {1'b0, r_len} + {11'd0, w_idx};
      w_len_add = w_len_sum[14] ? 14'h3FFF : w_len_sum[13:0];
   end

`ifdef FCS_CHECK_EN
   localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

   logic [31:0] r_crc, w_crc_upd;

   function automatic logic [31:0] crc_lanes(input logic [31:0] c,
                                             input logic [DATA_WIDTH-1:0] d,
                                             input logic [CTRL_WIDTH-1:0] k);
      logic [31:0] r;
      r = c;
      for (int j = 0; j < CTRL_WIDTH; j++) begin
         if (k[j]) begin
            r = r ^ {24'd0, d[DATA_WIDTH-1-8*j -: 8]};
            for (int b = 0; b < 8; b++) begin
               r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
            end
         end
      end
      return r;
   endfunction

   assign w_crc_upd = crc_lanes(r_crc, bus.i_rx_data, w_lane_keep);
   assign w_fcs_bad = (w_crc_upd != CRC_RESIDUE);

   // Running CRC over kept lanes, reseeded on every start block
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_crc <= 32'hFFFF_FFFF;
      end else if (w_start_ok) begin
         r_crc <= 32'hFFFF_FFFF;
      end else if (r_state == S_RECV) begin
         r_crc <= w_crc_upd;
      end
   end
`else
   assign w_fcs_bad = 1'b0;
`endif

   assign w_term_err = w_fcs_bad            ? 3'd5 :
                       (w_len_add > L_MAX)  ? 3'd4 :
                       (w_len_add < L_MIN)  ? 3'd3 : 3'd0;

   // Next state and next registered outputs
   always_comb begin
      w_state_nx = r_state;
      w_len_nx   = r_len;
      w_first_nx = r_first;
      w_keep     = '0;
      w_sof      = 1'b0;
      w_eof      = 1'b0;
      w_done     = 1'b0;
      w_err      = 3'd0;
      w_flen     = 14'd0;
      case (r_state)
         S_IDLE: begin
            if (w_start_ok) begin
               w_state_nx = S_RECV;
               w_len_nx   = 14'd0;
               w_first_nx = 1'b1;
            end else if (w_start_lane0) begin
               w_done = 1'b1;
               w_err  = 3'd1;
            end
         end
         S_RECV: begin
            if (w_start_ok) begin
               // old frame aborts and the new one begins in the same cycle
               w_done     = 1'b1;
               w_err      = 3'd2;
               w_eof      = 1'b1;
               w_flen     = r_len;
               w_len_nx   = 14'd0;
               w_first_nx = 1'b1;
            end else begin
               w_keep     = w_lane_keep;
               w_sof      = r_first;
               w_first_nx = 1'b0;
               w_len_nx   = w_len_add;
               if (w_idx < 4'(CTRL_WIDTH)) begin
                  w_state_nx = S_IDLE;
                  w_eof      = 1'b1;
                  w_done     = 1'b1;
                  w_flen     = w_len_add;
                  w_err      = (w_ctrl_char == TERMINATE_CODE) ? w_term_err : 3'd2;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nx;
   end

   // Datapath, registered outputs and saturating frame counters
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_len        <= '0;
         r_first      <= 1'b0;
         r_rx_data    <= '0;
         r_rx_keep    <= '0;
         r_rx_sof     <= 1'b0;
         r_rx_eof     <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= '0;
         r_flen       <= '0;
         r_good_count <= '0;
         r_bad_count  <= '0;
      end else begin
         r_len     <= w_len_nx;
         r_first   <= w_first_nx;
         r_rx_data <= bus.i_rx_data;
         r_rx_keep <= w_keep;
         r_rx_sof  <= w_sof;
         r_rx_eof  <= w_eof;
         r_done    <= w_done;
         r_err     <= w_err;
         r_flen    <= w_flen;
         if (w_done) begin
            if (w_err == 3'd0) begin
               if (r_good_count != '1) r_good_count <= r_good_count + 1'b1;
            end else begin
               if (r_bad_count != '1) r_bad_count <= r_bad_count + 1'b1;
            end
         end
      end
   end

   assign bus.o_rx_data = r_rx_data;
   assign bus.o_rx_keep = r_rx_keep;
   assign bus.o_rx_sof  = r_rx_sof;
   assign bus.o_rx_eof  = r_rx_eof;
   assign o_frame_done  = r_done;
   assign o_frame_err   = r_err;
   assign o_frame_len   = r_flen;
   assign o_good_count  = r_good_count;
   assign o_bad_count   = r_bad_count;

endmodule

// File: tb/tb_xgmii_frame_checker.sv
// Testbench for xgmii_frame_checker: a vector table for short frames plus
// hand sequences for long frames, FCS, length saturation and mid-frame reset.
module tb_xgmii_frame_checker;

   localparam logic [63:0] START_BLK = {8'hFB, {6{8'h55}}, 8'hD5};
   localparam logic [63:0] IDLE_BLK  = {8{8'h07}};
   localparam logic [63:0] TERM0_BLK = {8'hFD, {7{8'h07}}};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        done;
   logic [2:0]  err;
   logic [13:0] flen;
   logic [15:0] good, bad;

   always #5 clk = ~clk;

   xgmii_frame_checker_if bus ();

   xgmii_frame_checker dut (
      .clk          (clk),
      .i_rst_n      (rst_n),
      .bus          (bus),
      .o_frame_done (done),
      .o_frame_err  (err),
      .o_frame_len  (flen),
      .o_good_count (good),
      .o_bad_count  (bad)
   );

   typedef struct {
      logic [63:0] data;
      logic [7:0]  ctrl;
      logic [7:0]  keep;
      logic        sof;
      logic        eof;
      logic        eof_dc;
      logic        done;
      logic [2:0]  err;
      logic [13:0] len;
      logic [15:0] good;
      logic [15:0] bad;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_good, exp_bad;

   function automatic void add(input logic [63:0] d, input logic [7:0] c, input logic [7:0] k,
                               input logic s, input logic e, input logic edc, input logic dn,
                               input logic [2:0] er, input logic [13:0] ln,
                               input logic [15:0] g, input logic [15:0] b);
      vec_t v;
      v.data = d; v.ctrl = c; v.keep = k; v.sof = s; v.eof = e; v.eof_dc = edc;
      v.done = dn; v.err = er; v.len = ln; v.good = g; v.bad = b;
      vecs.push_back(v);
   endfunction

   function automatic logic [63:0] dblk(input int k);
      return 64'hA5C3_0000_0000_0000 | 64'(k * 977 + 5);
   endfunction

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   task automatic drive(input logic [63:0] d, input logic [7:0] c);
      @(negedge clk);
      bus.i_rx_data = d;
      bus.i_rx_ctrl = c;
      @(posedge clk);
      #1;
   endtask

   // Sends one frame of n bytes (last 4 are a correct FCS unless flip corrupts
   // a payload byte) and checks the completion against hand-derived values.
   task automatic send_frame(input int n, input bit flip, input string name);
      logic [7:0]  b[];
      logic [31:0] crc;
      logic [63:0] w;
      logic [7:0]  k_exp;
      logic [2:0]  e_exp;
      logic [13:0] l_exp;
      bit          early;
      bit          fcs_bad;
      int          nblk, rem;
      b = new[n];
      crc = 32'hFFFF_FFFF;
      for (int i = 0; i < n - 4; i++) begin
         b[i] = 8'(i * 7 + 3);
         crc  = crc_byte(crc, b[i]);
      end
      crc = ~crc;
      b[n-4] = crc[7:0];
      b[n-3] = crc[15:8];
      b[n-2] = crc[23:16];
      b[n-1] = crc[31:24];
      if (flip) b[10] = b[10] ^ 8'h04;
      nblk  = n / 8;
      rem   = n % 8;
      early = 1'b0;
      drive(START_BLK, 8'h01);
      if (done) early = 1'b1;
      for (int k = 0; k < nblk; k++) begin
         for (int l = 0; l < 8; l++) w[63-8*l -: 8] = b[8*k+l];
         drive(w, 8'h00);
         if (done) early = 1'b1;
      end
      for (int l = 0; l < 8; l++) begin
         if (l < rem)       w[63-8*l -: 8] = b[8*nblk+l];
         else if (l == rem) w[63-8*l -: 8] = 8'hFD;
         else               w[63-8*l -: 8] = 8'h07;
      end
      drive(w, 8'(8'hFF << rem));
`ifdef FCS_CHECK_EN
      fcs_bad = flip;
`else
      fcs_bad = 1'b0;
`endif
      l_exp = (n > 16383) ? 14'h3FFF : 14'(n);
      e_exp = fcs_bad ? 3'd5 : (n > 1518) ? 3'd4 : (n < 64) ? 3'd3 : 3'd0;
      k_exp = 8'((1 << rem) - 1);
      if (e_exp == 3'd0) exp_good++;
      else               exp_bad++;
      checks++;
      if (early) begin
         errors++;
         $display("FAIL %s body: frame_done seen before terminate, required none", name);
      end
      checks++;
      if (done !== 1'b1 || err !== e_exp || flen !== l_exp || bus.o_rx_keep !== k_exp ||
          bus.o_rx_eof !== 1'b1 || good !== 16'(exp_good) || bad !== 16'(exp_bad)) begin
         errors++;
         $display("FAIL %s end: got done=%b err=%0d len=%0d keep=%h eof=%b good=%0d bad=%0d, required done=1 err=%0d len=%0d keep=%h eof=1 good=%0d bad=%0d",
                  name, done, err, flen, bus.o_rx_keep, bus.o_rx_eof, good, bad,
                  e_exp, l_exp, k_exp, exp_good, exp_bad);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_rx_data = IDLE_BLK;
      bus.i_rx_ctrl = 8'hFF;

      // frame 1: 64 bytes, good
      add(START_BLK, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) add(dblk(i), 8'h00, 8'hFF, i == 0, 0, 0, 0, 0, 0, 0, 0);
      add(TERM0_BLK, 8'h01, 8'h00, 0, 1, 0, 1, 0, 64, 1, 0);
      add(IDLE_BLK, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
      // frame 2: 60 bytes, runt
      add(START_BLK, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) add(dblk(i + 10), 8'h00, 8'hFF, i == 0, 0, 0, 0, 0, 0, 1, 0);
      add({32'hDEADBEEF, 8'hFD, 24'h070707}, 8'hF0, 8'h0F, 0, 1, 0, 1, 3, 60, 1, 1);
      // malformed start (SFD missing), then blocks ignored in IDLE
      add({8'hFB, {7{8'h55}}}, 8'h01, 8'h00, 0, 0, 0, 1, 1, 0, 1, 2);
      add(IDLE_BLK, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 0, 1, 2);
      add(dblk(50), 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 2);
      // frame aborted by FE in lane 2 after 26 bytes, new start right after
      add(START_BLK, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 1, 2);
      for (int i = 0; i < 3; i++) add(dblk(i + 20), 8'h00, 8'hFF, i == 0, 0, 0, 0, 0, 0, 1, 2);
      add({16'hCAFE, 8'hFE, 40'h0707070707}, 8'hFC, 8'h03, 0, 0, 1, 1, 2, 26, 1, 3);
      add(START_BLK, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 1, 3);
      for (int i = 0; i < 8; i++) add(dblk(i + 30), 8'h00, 8'hFF, i == 0, 0, 0, 0, 0, 0, 1, 3);
      add(TERM0_BLK, 8'h01, 8'h00, 0, 1, 0, 1, 0, 64, 2, 3);
      // start inside a frame: abort after 16 bytes and restart in the same cycle
      add(START_BLK, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 2, 3);
      for (int i = 0; i < 2; i++) add(dblk(i + 40), 8'h00, 8'hFF, i == 0, 0, 0, 0, 0, 0, 2, 3);
      add(START_BLK, 8'h01, 8'h00, 0, 0, 1, 1, 2, 16, 2, 4);
      for (int i = 0; i < 8; i++) add(dblk(i + 60), 8'h00, 8'hFF, i == 0, 0, 0, 0, 0, 0, 2, 4);
      add(TERM0_BLK, 8'h01, 8'h00, 0, 1, 0, 1, 0, 64, 3, 4);
      // empty frame: terminate directly after start
      add(START_BLK, 8'h01, 8'h00, 0, 0, 0, 0, 0, 0, 3, 4);
      add(TERM0_BLK, 8'h01, 8'h00, 1, 1, 0, 1, 3, 0, 3, 5);
      add(IDLE_BLK, 8'hFF, 8'h00, 0, 0, 0, 0, 0, 0, 3, 5);

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.o_rx_data !== 64'd0 || bus.o_rx_keep !== 8'd0 || bus.o_rx_sof !== 1'b0 ||
          bus.o_rx_eof !== 1'b0 || done !== 1'b0 || err !== 3'd0 || flen !== 14'd0 ||
          good !== 16'd0 || bad !== 16'd0) begin
         errors++;
         $display("FAIL reset: got data=%h keep=%h sof=%b eof=%b done=%b err=%0d len=%0d good=%0d bad=%0d, required all zero",
                  bus.o_rx_data, bus.o_rx_keep, bus.o_rx_sof, bus.o_rx_eof, done, err, flen, good, bad);
      end
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].data, vecs[i].ctrl);
         checks++;
         if (bus.o_rx_data !== vecs[i].data || bus.o_rx_keep !== vecs[i].keep ||
             bus.o_rx_sof !== vecs[i].sof ||
             (!vecs[i].eof_dc && bus.o_rx_eof !== vecs[i].eof) ||
             done !== vecs[i].done || err !== vecs[i].err || flen !== vecs[i].len ||
             good !== vecs[i].good || bad !== vecs[i].bad) begin
            errors++;
            $display("FAIL vec%0d: got data=%h keep=%h sof=%b eof=%b done=%b err=%0d len=%0d good=%0d bad=%0d, required data=%h keep=%h sof=%b eof=%b done=%b err=%0d len=%0d good=%0d bad=%0d",
                     i, bus.o_rx_data, bus.o_rx_keep, bus.o_rx_sof, bus.o_rx_eof, done, err, flen, good, bad,
                     vecs[i].data, vecs[i].keep, vecs[i].sof, vecs[i].eof, vecs[i].done,
                     vecs[i].err, vecs[i].len, vecs[i].good, vecs[i].bad);
         end
      end

      exp_good = 3;
      exp_bad  = 5;
      send_frame(1514, 1'b0, "len1514");
      send_frame(1514, 1'b1, "len1514_flip");
      send_frame(1600, 1'b0, "len1600");
      send_frame(16400, 1'b0, "len_sat");

      // reset in the middle of a frame: silent discard, everything cleared
      drive(START_BLK, 8'h01);
      drive(dblk(90), 8'h00);
      drive(dblk(91), 8'h00);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_rx_data !== 64'd0 || bus.o_rx_keep !== 8'd0 || bus.o_rx_sof !== 1'b0 ||
          bus.o_rx_eof !== 1'b0 || done !== 1'b0 || err !== 3'd0 || flen !== 14'd0 ||
          good !== 16'd0 || bad !== 16'd0) begin
         errors++;
         $display("FAIL midreset: got data=%h keep=%h sof=%b eof=%b done=%b err=%0d len=%0d good=%0d bad=%0d, required all zero",
                  bus.o_rx_data, bus.o_rx_keep, bus.o_rx_sof, bus.o_rx_eof, done, err, flen, good, bad);
      end
      bus.i_rx_data = IDLE_BLK;
      bus.i_rx_ctrl = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      drive(TERM0_BLK, 8'h01);
      checks++;
      if (done !== 1'b0 || bus.o_rx_keep !== 8'd0 || bus.o_rx_eof !== 1'b0 ||
          good !== 16'd0 || bad !== 16'd0) begin
         errors++;
         $display("FAIL post_reset_term: got done=%b keep=%h eof=%b good=%0d bad=%0d, required done=0 keep=00 eof=0 good=0 bad=0",
                  done, bus.o_rx_keep, bus.o_rx_eof, good, bad);
      end
      exp_good = 0;
      exp_bad  = 0;
      send_frame(64, 1'b0, "post_reset_min");

      drive(IDLE_BLK, 8'hFF);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
